// File: rtl/sd_route_pkg.sv
// -----------------------------------------------------------------------------
// sd_route_pkg
// Shared types and constants for the SPI SD route controller.
//   route_state_t : route-switch FSM states
//   ROUTE_PHYS    : vsd_sel value selecting the physical SD slot
//   ROUTE_VIRT    : vsd_sel value selecting the virtual (HPS image) SD
// -----------------------------------------------------------------------------
package sd_route_pkg;

    typedef enum logic [1:0] {
        ST_STABLE  = 2'b00,
        ST_PENDING = 2'b01,
        ST_GUARD   = 2'b10
    } route_state_t;

    localparam logic ROUTE_PHYS = 1'b0;
    localparam logic ROUTE_VIRT = 1'b1;

endpackage

// File: rtl/sd_route_ctrl_act_stretch.sv
// -----------------------------------------------------------------------------
// act_stretch
// Drive-activity LED stretcher. While the SD chip select is active the
// counter is held at LED_STRETCH; once it deasserts the counter runs down
// to zero, keeping the LED lit for LED_STRETCH cycles after the access.
// Ports:
//   clk_sys   in  system clock
//   reset     in  synchronous, active-high reset
//   spi_ss    in  core chip select, active low
//   drive_led out activity indicator, active high
// -----------------------------------------------------------------------------
module act_stretch #(
    parameter int LED_STRETCH = 2000000,
    parameter int CNT_W       = 24
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic spi_ss,
    output logic drive_led
);

    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(LED_STRETCH);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] led_cnt_q;
    logic [CNT_W-1:0] led_cnt_d;

    // Next value of the stretch counter: reload while busy, else count down.
    always_comb begin
        led_cnt_d = led_cnt_q;
        if (spi_ss == 1'b0) begin
            led_cnt_d = STRETCH_LOAD;
        end else if (led_cnt_q != CNT_ZERO) begin
            led_cnt_d = led_cnt_q - CNT_ONE;
        end else begin
            led_cnt_d = led_cnt_q;
        end
    end

    // Stretch counter register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            led_cnt_q <= CNT_ZERO;
        end else begin
            led_cnt_q <= led_cnt_d;
        end
    end

    // The live chip select lights the LED immediately; the counter covers the tail.
    assign drive_led = (led_cnt_q != CNT_ZERO) | ~spi_ss;

endmodule

// File: rtl/sd_route_ctrl.sv
// -----------------------------------------------------------------------------
// sd_route_ctrl
// Routes the core's SPI SD bus either to the virtual SD (image served by the
// HPS) or to the physical SD slot. A mount event only records the wanted
// route; the switch is applied after IDLE_CYCLES consecutive quiet cycles
// (spi_ss high), with one guard cycle in which neither device is selected.
// Ports:
//   clk_sys, reset               clock and synchronous active-high reset
//   img_mounted, img_present     mount event pulse and "image present" flag
//   spi_ss/sck/mosi, spi_miso    core-side SPI
//   vsd_ss, vsd_miso             virtual SD side
//   sd_cs/sck/mosi, sd_miso      physical SD slot side
//   vsd_sel                      current route (1 = virtual)
//   switch_pending               route change waiting for bus quiet
//   drive_led                    stretched activity indicator
// -----------------------------------------------------------------------------
module sd_route_ctrl
    import sd_route_pkg::*;
#(
    parameter int IDLE_CYCLES = 64,
    parameter int LED_STRETCH = 2000000,
    parameter int CNT_W       = 24
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic img_mounted,
    input  logic img_present,
    input  logic spi_ss,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic vsd_ss,
    input  logic vsd_miso,
    output logic sd_cs,
    output logic sd_sck,
    output logic sd_mosi,
    input  logic sd_miso,
    output logic vsd_sel,
    output logic switch_pending,
    output logic drive_led
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    route_state_t     state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             vsd_sel_q, vsd_sel_d;
    logic             target_q, target_d;
    logic             guard_q, guard_d;
    logic             switch_pending_q, switch_pending_d;

    // Wanted route and route-switch FSM next state.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        vsd_sel_d  = vsd_sel_q;
        guard_d    = 1'b0;

        // A mount event always wins over any other target update.
        if (img_mounted) begin
            target_d = img_present;
        end else begin
            target_d = target_q;
        end

        case (state_q)
            ST_STABLE: begin
                idle_cnt_d = CNT_ZERO;
                if (target_q != vsd_sel_q) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_PENDING: begin
                if (target_q == vsd_sel_q) begin
                    // Re-mount restored the current route: drop the request quietly.
                    state_d    = ST_STABLE;
                    idle_cnt_d = CNT_ZERO;
                end else if (spi_ss == 1'b0) begin
                    idle_cnt_d = CNT_ZERO;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    if (img_mounted) begin
                        // Target is about to change; re-evaluate it before switching.
                        idle_cnt_d = CNT_ZERO;
                    end else begin
                        state_d    = ST_GUARD;
                        guard_d    = 1'b1;
                        vsd_sel_d  = target_q;
                        idle_cnt_d = CNT_ZERO;
                    end
                end else if (idle_cnt_q != CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
            end
            ST_GUARD: begin
                state_d    = ST_STABLE;
                idle_cnt_d = CNT_ZERO;
            end
            default: begin
                state_d    = ST_STABLE;
                idle_cnt_d = CNT_ZERO;
                vsd_sel_d  = ROUTE_PHYS;
            end
        endcase

        switch_pending_d = (state_d == ST_PENDING);
    end

    // Route-switch state registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q          <= ST_STABLE;
            idle_cnt_q       <= CNT_ZERO;
            vsd_sel_q        <= ROUTE_PHYS;
            target_q         <= ROUTE_PHYS;
            guard_q          <= 1'b0;
            switch_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            idle_cnt_q       <= idle_cnt_d;
            vsd_sel_q        <= vsd_sel_d;
            target_q         <= target_d;
            guard_q          <= guard_d;
            switch_pending_q <= switch_pending_d;
        end
    end

    // Zero-latency routing; guard forces both devices deselected and idle.
    assign vsd_ss   = spi_ss | (vsd_sel_q != ROUTE_VIRT) | guard_q;
    assign sd_cs    = spi_ss | (vsd_sel_q != ROUTE_PHYS) | guard_q;
    assign sd_sck   = spi_sck  & (vsd_sel_q == ROUTE_PHYS) & ~guard_q;
    assign sd_mosi  = spi_mosi & (vsd_sel_q == ROUTE_PHYS) & ~guard_q;
    assign spi_miso = guard_q ? 1'b1 : ((vsd_sel_q == ROUTE_VIRT) ? vsd_miso : sd_miso);

    assign vsd_sel        = vsd_sel_q;
    assign switch_pending = switch_pending_q;

    act_stretch #(
        .LED_STRETCH (LED_STRETCH),
        .CNT_W       (CNT_W)
    ) u_act_stretch (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .spi_ss    (spi_ss),
        .drive_led (drive_led)
    );

endmodule

// File: tb/tb_sd_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_route_ctrl
// Stimulus process drives one input vector per clock and pushes the outputs
// a reference model predicts for that cycle; a monitor process pops and
// compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_sd_route_ctrl;

    localparam int IDLE = 4;
    localparam int LED  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic img_mounted = 1'b0;
    logic img_present = 1'b0;
    logic spi_ss = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_mosi = 1'b0;
    logic vsd_miso = 1'b0;
    logic sd_miso = 1'b0;
    logic spi_miso, vsd_ss, sd_cs, sd_sck, sd_mosi, vsd_sel, switch_pending, drive_led;

    sd_route_ctrl #(
        .IDLE_CYCLES (IDLE),
        .LED_STRETCH (LED),
        .CNT_W       (8)
    ) dut (
        .clk_sys        (clk),
        .reset          (reset),
        .img_mounted    (img_mounted),
        .img_present    (img_present),
        .spi_ss         (spi_ss),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .vsd_ss         (vsd_ss),
        .vsd_miso       (vsd_miso),
        .sd_cs          (sd_cs),
        .sd_sck         (sd_sck),
        .sd_mosi        (sd_mosi),
        .sd_miso        (sd_miso),
        .vsd_sel        (vsd_sel),
        .switch_pending (switch_pending),
        .drive_led      (drive_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    bit   stim_done = 1'b0;
    int   cyc = 0;

    // Reference model: what the route controller has remembered so far.
    bit m_route  = 1'b0;   // 1 = virtual SD serves the bus
    bit m_target = 1'b0;   // route asked for by the latest mount
    bit m_wait   = 1'b0;   // a route change is waiting for a quiet bus
    bit m_guard  = 1'b0;   // this cycle is the dead cycle of a switch
    int m_quiet  = 0;      // consecutive quiet cycles seen while waiting
    int m_led    = 0;      // remaining LED afterglow cycles

    // Advance the model by one clock using the inputs the DUT just sampled.
    function automatic void model_advance();
        bit next_target;
        if (reset) begin
            m_route = 1'b0; m_target = 1'b0; m_wait = 1'b0;
            m_guard = 1'b0; m_quiet = 0; m_led = 0;
            return;
        end
        next_target = img_mounted ? img_present : m_target;
        if (m_guard) begin
            m_guard = 1'b0;
        end else if (!m_wait) begin
            if (m_target != m_route) begin
                m_wait  = 1'b1;
                m_quiet = 0;
            end
        end else if (m_target == m_route) begin
            m_wait = 1'b0;
        end else if (!spi_ss) begin
            m_quiet = 0;
        end else if (m_quiet + 1 == IDLE) begin
            if (img_mounted) begin
                m_quiet = 0;
            end else begin
                m_wait  = 1'b0;
                m_guard = 1'b1;
                m_route = m_target;
                m_quiet = 0;
            end
        end else begin
            m_quiet = m_quiet + 1;
        end
        m_led    = !spi_ss ? LED : ((m_led > 0) ? m_led - 1 : 0);
        m_target = next_target;
    endfunction

    // Expected output vector for the current model state and inputs.
    function automatic logic [7:0] model_outputs();
        bit virt_live = !m_guard && m_route;
        bit phys_live = !m_guard && !m_route;
        bit miso_e    = m_guard ? 1'b1 : (m_route ? vsd_miso : sd_miso);
        return {miso_e,
                !(virt_live && !spi_ss),
                !(phys_live && !spi_ss),
                phys_live && spi_sck,
                phys_live && spi_mosi,
                m_route,
                m_wait,
                (m_led > 0) || !spi_ss};
    endfunction

    task automatic step(input bit r, input bit m, input bit p,
                        input bit ss, input bit sck, input bit mosi);
        exp_t e;
        @(posedge clk);
        model_advance();
        #1;
        reset       = r;
        img_mounted = m;
        img_present = p;
        spi_ss      = ss;
        spi_sck     = sck;
        spi_mosi    = mosi;
        vsd_miso    = 1'($urandom_range(0, 1));
        sd_miso     = 1'($urandom_range(0, 1));
        cyc         = cyc + 1;
        e.exp = model_outputs();
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input bit ss);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, ss, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Stimulus: directed scenarios first, then a long randomized run.
    initial begin
        int  run_left;
        bit  cur_ss;
        run_left = 0;
        cur_ss   = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(10, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'(i % 2), 1'b1);
        run(2, 1'b1);
        // mount while idle: switch to virtual after the quiet window + guard
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run(8, 1'b1);
        // unmount while the bus is busy: waits for spi_ss to rise
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(20, 1'b0);
        run(8, 1'b1);
        // mount, then a select pulse at quiet count 3 restarts the window
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run(4, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run(8, 1'b1);
        // request back to physical, then restore virtual: abort without guard
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run(6, 1'b1);
        // mount landing exactly on the completion cycle
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(4, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(8, 1'b1);
        // LED afterglow
        run(3, 1'b0);
        run(12, 1'b1);
        // reset while a change is pending
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run(3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(4, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                cur_ss   = ($urandom_range(0, 9) < 7);
                run_left = cur_ss ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 6));
            end
            run_left = run_left - 1;
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), cur_ss,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stim_done = 1'b1;
    end

    // Monitor: compare the DUT outputs against the oldest prediction.
    initial begin
        int n_chk;
        int n_pass;
        int drain;
        exp_t e;
        logic [7:0] act;
        n_chk  = 0;
        n_pass = 0;
        drain  = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {spi_miso, vsd_ss, sd_cs, sd_sck, sd_mosi, vsd_sel, switch_pending, drive_led};
                n_chk = n_chk + 1;
                if (act === e.exp) begin
                    n_pass = n_pass + 1;
                end else begin
                    $display("FAIL outputs cycle %0d: actual=%b required=%b (miso,vsd_ss,sd_cs,sd_sck,sd_mosi,vsd_sel,pending,led)",
                             e.cyc, act, e.exp);
                end
            end
            if (stim_done) begin
                if (sb.size() == 0) begin
                    $display("%0d/%0d checks passed", n_pass, n_chk);
                    $finish;
                end
                drain = drain + 1;
                if (drain > 4) begin
                    n_chk = n_chk + 1;
                    $display("FAIL drain: %0d predictions left unchecked, required 0", sb.size());
                    $display("%0d/%0d checks passed", n_pass, n_chk);
                    $finish;
                end
            end
        end
    end

endmodule

// File: doc/sd_route_ctrl.md
Name: sd_route_ctrl

Overview:
- Owns the SPI SD path between the Microcomputer core, the virtual SD (sd_card over HPS image) and the physical SD slot.
- Replaces the free-running select flop.
- A route change requested by an image mount is applied only once the SPI bus has been quiet. A one-cycle guard deselects both devices during the change.
- Also generates the stretched drive-activity LED.

Parameters:
- IDLE_CYCLES, 64: consecutive cycles with spi_ss high required before a pending route switch is applied (≥2).
- LED_STRETCH, 2000000: cycles drive_led stays high after spi_ss deasserts.
- CNT_W, 24: width of the idle and LED counters; must hold max(IDLE_CYCLES, LED_STRETCH).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- img_mounted  in  1  one-cycle pulse: image mount or unmount event.
- img_present  in  1  |img_size, sampled with img_mounted.
- spi_ss  in  1  core chip select, active low.
- spi_sck  in  1  core SPI clock.
- spi_mosi  in  1  core MOSI.
- spi_miso  out  1  MISO returned to core.
- vsd_ss  out  1  virtual SD select, active low.
- vsd_miso  in  1  virtual SD MISO.
- sd_cs  out  1  physical SD chip select, active low.
- sd_sck  out  1  physical SD clock.
- sd_mosi  out  1  physical SD MOSI.
- sd_miso  in  1  physical SD MISO.
- vsd_sel  out  1  current route (1 = virtual).
- switch_pending  out  1  a route change is waiting for bus quiet.
- drive_led  out  1  activity indicator, active high.

Behaviour:
- Reset values: vsd_sel=0, target=0, state=STABLE, idle_cnt=0, led_cnt=0, guard=0, drive_led=0, switch_pending=0.
  - Resulting outputs: sd_cs=spi_ss, vsd_ss=1.
- Routing is combinational, with zero latency, from the registered vsd_sel and guard:
  - vsd_ss = spi_ss | ~vsd_sel | guard.
  - sd_cs = spi_ss | vsd_sel | guard.
  - sd_sck = spi_sck & ~vsd_sel & ~guard.
  - sd_mosi = spi_mosi & ~vsd_sel & ~guard.
  - spi_miso = guard ? 1 : (vsd_sel ? vsd_miso : sd_miso).
- Target latch: on img_mounted, target <= img_present. This takes priority over any other target update in the same cycle.
- FSM states: STABLE, PENDING, GUARD.
  - STABLE: if target != vsd_sel, go to PENDING with idle_cnt=0.
  - PENDING:
    - switch_pending=1.
    - spi_ss=0 clears idle_cnt; spi_ss=1 increments it, saturating.
    - When idle_cnt == IDLE_CYCLES-1 and spi_ss=1: go to GUARD, set guard=1 and vsd_sel <= target.
    - If target == vsd_sel at any time (re-mount restored the original), abort to STABLE without a guard cycle.
    - The current route keeps serving transactions while PENDING.
  - GUARD: exactly one cycle with both devices deselected. Then go to STABLE with guard=0.
    - If target changed again during GUARD, the next STABLE cycle re-enters PENDING.
- Simultaneous img_mounted and idle completion in one cycle: the completion is ignored, and the new target is evaluated next cycle. If the new target still differs from vsd_sel, the FSM stays PENDING and idle_cnt restarts at 0.
- spi_ss falling during the completion cycle: no switch; idle_cnt clears.
- LED:
  - spi_ss low: led_cnt <= LED_STRETCH.
  - Otherwise, if led_cnt != 0: led_cnt decrements.
  - drive_led = (led_cnt != 0) | ~spi_ss, independent of route.
- Reset asserted mid-PENDING or mid-GUARD: the next cycle is the reset state. The route returns to physical, and any pending request is discarded.

Decomposition:
- Package sd_route_pkg:
  - typedef enum logic [1:0] {ST_STABLE, ST_PENDING, ST_GUARD} route_state_t.
  - Constants ROUTE_PHYS=1'b0 and ROUTE_VIRT=1'b1.
- One natural sub-module: act_stretch (LED down-counter, parameter LED_STRETCH). The FSM and routing stay in sd_route_ctrl.

Test Plan (all with IDLE_CYCLES=4, LED_STRETCH=8):
- Reset, then spi_ss=1 for 10 cycles -> vsd_sel=0, vsd_ss=1, sd_cs=1, drive_led=0.
  - Then spi_sck toggling with spi_ss=0 -> sd_sck follows spi_sck in the same cycle; vsd_ss stays 1.
- img_mounted=1 with img_present=1 while spi_ss=1 -> switch_pending=1 next cycle.
  - vsd_sel=1 after 4 idle cycles, preceded by exactly one guard cycle (vsd_ss=1, sd_cs=1, spi_miso=1).
- Mount while spi_ss=0 for 20 cycles -> vsd_sel stays 0 and sd_cs tracks spi_ss throughout.
  - Switch occurs 4 cycles after spi_ss rises.
  - spi_ss pulsed low at idle count 3 -> count restarts.
- Mount present=1, then after 2 cycles mount present=0 -> abort to STABLE, no guard cycle, vsd_sel=0.
  - Separately, img_mounted in the same cycle as idle completion -> no switch that cycle.
- spi_ss low for 3 cycles then high -> drive_led high for those 3 cycles plus 8 more, then 0.
  - Reset asserted while PENDING -> next cycle state STABLE, vsd_sel=0, switch_pending=0, drive_led=0.
